// File: rtl/mem_access_ctrl_if.sv
// Data-memory / peripheral bus seen by the memory-stage controller.
// The controller is the master: it issues one request at a time and holds
// it until the slave signals completion with bus_ready.
interface mem_access_ctrl_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    output bus_byteen,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    input  bus_byteen,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller.
// Screens each M-stage load/store for alignment and address-map faults,
// runs a single outstanding bus transaction per access, stalls the
// pipeline while it is in flight and hands the raw read word, byte offset
// and extension opcode to the data-extension unit.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  mem_access_ctrl_if.master bus,
  output logic        stall,
  output logic        done,
  output logic [31:0] de_rdata,
  output logic [1:0]  de_a,
  output logic [2:0]  de_op,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LB   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LH   = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  typedef enum logic [2:0] {
    DE_LW  = 3'd0,
    DE_LBU = 3'd1,
    DE_LB  = 3'd2,
    DE_LHU = 3'd3,
    DE_LH  = 3'd4
  } de_op_e;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5
  } exc_code_e;

  state_e      state;
  state_e      state_n;

  // decoded request
  logic        is_load;
  logic        is_store;
  logic        size_word;
  logic        size_half;
  de_op_e      de_op_n;
  logic [3:0]  byteen_n;
  logic [31:0] wdata_n;
  logic        op_valid;

  // address screening
  logic        in_dm;
  logic        in_t0;
  logic        in_t1;
  logic        in_ig;
  logic        in_timer;
  logic        in_map;
  logic        misaligned;
  logic        sub_to_timer;
  logic        count_store;
  logic        fault;

  // latched transaction
  logic [31:0] addr_q;
  logic [3:0]  byteen_q;
  logic [31:0] wdata_q;
  logic        is_load_q;
  logic [1:0]  de_a_q;
  logic [2:0]  de_op_q;
  logic [31:0] de_rdata_q;
  logic        cancel_q;

  logic        accept;
  logic        bus_req_n;

  // Decode the M-stage opcode into access size, direction, DE opcode and
  // the store lane layout; undefined codes decode to "no access".
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    size_word = 1'b0;
    size_half = 1'b0;
    de_op_n   = DE_LW;
    byteen_n  = '0;
    wdata_n   = wdata;
    case (mem_op)
      OP_LW: begin
        is_load   = 1'b1;
        size_word = 1'b1;
        de_op_n   = DE_LW;
      end
      OP_LBU: begin
        is_load = 1'b1;
        de_op_n = DE_LBU;
      end
      OP_LB: begin
        is_load = 1'b1;
        de_op_n = DE_LB;
      end
      OP_LHU: begin
        is_load   = 1'b1;
        size_half = 1'b1;
        de_op_n   = DE_LHU;
      end
      OP_LH: begin
        is_load   = 1'b1;
        size_half = 1'b1;
        de_op_n   = DE_LH;
      end
      OP_SW: begin
        is_store  = 1'b1;
        size_word = 1'b1;
        byteen_n  = '1;
        wdata_n   = wdata;
      end
      OP_SH: begin
        is_store  = 1'b1;
        size_half = 1'b1;
        byteen_n  = addr[1] ? 4'b1100 : 4'b0011;
        wdata_n   = {2{wdata[15:0]}};
      end
      OP_SB: begin
        is_store = 1'b1;
        byteen_n = 4'b0001 << addr[1:0];
        wdata_n  = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign op_valid = is_load | is_store;

  // Address map regions (byte address of the access).
  assign in_dm    = (addr <= 32'h0000_2FFF);
  assign in_t0    = (addr >= 32'h0000_7F00) && (addr <= 32'h0000_7F0B);
  assign in_t1    = (addr >= 32'h0000_7F10) && (addr <= 32'h0000_7F1B);
  assign in_ig    = (addr >= 32'h0000_7F20) && (addr <= 32'h0000_7F23);
  assign in_timer = in_t0 | in_t1;
  assign in_map   = in_dm | in_timer | in_ig;

  // Timers only take whole-word accesses and their COUNT word (offset 0x8)
  // is read-only.
  assign misaligned   = (size_word && (addr[1:0] != 2'b00)) ||
                        (size_half && addr[0]);
  assign sub_to_timer = in_timer && !size_word;
  assign count_store  = is_store && in_timer && (addr[3:2] == 2'b10);
  assign fault        = misaligned || !in_map || sub_to_timer || count_store;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and handshake/pipeline outputs.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    bus_req_n = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    exc_valid = 1'b0;
    exc_code  = EXC_NONE;
    case (state)
      IDLE: begin
        if (req_valid && op_valid && !flush) begin
          if (fault) begin
            exc_valid = 1'b1;
            exc_code  = is_store ? EXC_ADES : EXC_ADEL;
          end else begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        bus_req_n = 1'b1;
        stall     = 1'b1;
        if (bus.bus_ready) begin
          state_n = DONE;
        end
      end
      DONE: begin
        // A flush seen while the bus was busy, or one arriving now, means
        // the instruction is gone: the access still happened but DE must
        // not consume it.
        done    = !cancel_q && !flush;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Transaction latch, read-data capture and sticky cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      byteen_q   <= '0;
      wdata_q    <= '0;
      is_load_q  <= 1'b0;
      de_a_q     <= '0;
      de_op_q    <= '0;
      de_rdata_q <= '0;
      cancel_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= {addr[31:2], 2'b00};
        byteen_q  <= byteen_n;
        wdata_q   <= wdata_n;
        is_load_q <= is_load;
        de_a_q    <= addr[1:0];
        de_op_q   <= de_op_n;
        cancel_q  <= 1'b0;
      end
      if (state == WAIT) begin
        if (flush) begin
          cancel_q <= 1'b1;
        end
        if (bus.bus_ready && is_load_q) begin
          de_rdata_q <= bus.bus_rdata;
        end
      end
      if (state == DONE) begin
        cancel_q <= 1'b0;
      end
    end
  end

  assign bus.bus_req    = bus_req_n;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_byteen = byteen_q;
  assign bus.bus_wdata  = wdata_q;

  assign de_rdata = de_rdata_q;
  assign de_a     = de_a_q;
  assign de_op    = de_op_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios followed by
// randomized accesses, all compared against a transaction-level model of
// the address map, lane layout and handshake timing.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] de_rdata;
  logic [1:0]  de_a;
  logic [2:0]  de_op;
  logic        exc_valid;
  logic [4:0]  exc_code;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] model_rdata;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .flush     (flush),
    .bus       (bus_if),
    .stall     (stall),
    .done      (done),
    .de_rdata  (de_rdata),
    .de_a      (de_a),
    .de_op     (de_op),
    .exc_valid (exc_valid),
    .exc_code  (exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd6:       return 4;
      4'd4, 4'd5, 4'd7: return 2;
      default:          return 1;
    endcase
  endfunction

  function automatic bit op_is_valid(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  // Expected exception code for a request (0 = none).
  function automatic logic [4:0] exp_code(input logic [3:0] op, input logic [31:0] a);
    int unsigned sz;
    bit st, dm, tmr, ig, bad;
    if (!op_is_valid(op)) return 5'd0;
    st  = op_is_store(op);
    sz  = op_size(op);
    dm  = (a <= 32'h2FFF);
    tmr = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
    ig  = (a >= 32'h7F20 && a <= 32'h7F23);
    bad = ((a % sz) != 0) || !(dm || tmr || ig) || (tmr && sz != 4) ||
          (st && tmr && (a % 16) == 8);
    if (!bad) return 5'd0;
    return st ? 5'd5 : 5'd4;
  endfunction

  function automatic logic [3:0] exp_byteen(input logic [3:0] op, input logic [31:0] a);
    int unsigned sz;
    logic [3:0] m;
    if (!op_is_store(op)) return 4'b0000;
    sz = op_size(op);
    m  = 4'((1 << sz) - 1);
    return 4'(m << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] wd);
    case (op_size(op))
      4:       return wd;
      2:       return (wd & 32'h0000_FFFF) * 32'h0001_0001;
      default: return (wd & 32'h0000_00FF) * 32'h0101_0101;
    endcase
  endfunction

  function automatic logic [2:0] exp_de_op(input logic [3:0] op);
    case (op)
      4'd2:    return 3'd1;
      4'd3:    return 3'd2;
      4'd4:    return 3'd3;
      4'd5:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // One complete access: request in IDLE, 'waits' cycles without ready,
  // then ready; optional flush in IDLE or in WAIT cycle flush_at.
  task automatic run_access(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input int waits,
                            input int flush_at, input logic idle_flush,
                            input logic [31:0] rd);
    logic [4:0] code;
    bit         cancelled;
    code      = exp_code(op, a);
    req_valid = 1'b1;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    flush     = idle_flush;
    bus_if.bus_ready = 1'b0;
    #1;
    if (idle_flush || !op_is_valid(op) || code != 5'd0) begin
      check("exc_valid", exc_valid, (!idle_flush && code != 5'd0));
      check("exc_code", exc_code, idle_flush ? 5'd0 : code);
      check("stall_noacc", stall, 0);
      check("bus_req_noacc", bus_if.bus_req, 0);
      step();
      req_valid = 1'b0;
      flush     = 1'b0;
      #1;
      check("bus_req_after_noacc", bus_if.bus_req, 0);
      check("stall_after_noacc", stall, 0);
      return;
    end
    check("stall_accept", stall, 1);
    check("exc_valid_accept", exc_valid, 0);
    check("bus_req_accept", bus_if.bus_req, 0);
    step();
    cancelled = 0;
    for (int i = 0; i <= waits; i++) begin
      flush = (i == flush_at);
      bus_if.bus_ready = (i == waits);
      bus_if.bus_rdata = (i == waits) ? rd : $urandom;
      #1;
      check("bus_req_wait", bus_if.bus_req, 1);
      check("stall_wait", stall, 1);
      check("done_wait", done, 0);
      check("bus_addr", bus_if.bus_addr, a & 32'hFFFF_FFFC);
      check("bus_byteen", bus_if.bus_byteen, exp_byteen(op, a));
      if (op_is_store(op)) check("bus_wdata", bus_if.bus_wdata, exp_wdata(op, wd));
      if (flush) cancelled = 1;
      step();
    end
    bus_if.bus_ready = 1'b0;
    flush = 1'b0;
    #1;
    if (!op_is_store(op)) model_rdata = rd;
    check("done", done, !cancelled);
    check("bus_req_done", bus_if.bus_req, 0);
    check("stall_done", stall, 0);
    check("de_a", de_a, a % 4);
    check("de_op", de_op, exp_de_op(op));
    check("de_rdata", de_rdata, model_rdata);
    step();
    req_valid = 1'b0;
    #1;
    check("done_idle", done, 0);
    check("bus_req_idle", bus_if.bus_req, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0, 1:    return $urandom_range(0, 32'h2FFF);
      2:       return 32'h7F00 + $urandom_range(0, 15);
      3:       return 32'h7F10 + $urandom_range(0, 15);
      4:       return 32'h7F20 + $urandom_range(0, 7);
      5:       return 32'h2FF8 + $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    model_rdata = '0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    mem_op      = '0;
    addr        = '0;
    wdata       = '0;
    flush       = 1'b0;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_bus_req", bus_if.bus_req, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_de_rdata", de_rdata, 0);
    check("rst_de_a", de_a, 0);
    check("rst_de_op", de_op, 0);
    check("rst_bus_addr", bus_if.bus_addr, 0);
    check("rst_byteen", bus_if.bus_byteen, 0);
    check("rst_exc", exc_valid, 0);
    step();

    // directed scenarios
    run_access(4'd3, 32'h0000_0103, 32'h0, 0, -1, 1'b0, 32'h8000_0000);
    run_access(4'd7, 32'h0000_0202, 32'h1234_ABCD, 3, -1, 1'b0, 32'hDEAD_BEEF);
    run_access(4'd1, 32'h0000_0006, 32'h0, 0, -1, 1'b0, 32'h0);
    run_access(4'd6, 32'h0000_7F08, 32'h5, 0, -1, 1'b0, 32'h0);
    run_access(4'd3, 32'h0000_7F00, 32'h0, 0, -1, 1'b0, 32'h0);
    run_access(4'd1, 32'h0000_3000, 32'h0, 0, -1, 1'b0, 32'h0);
    run_access(4'd1, 32'h0000_7F08, 32'h0, 1, -1, 1'b0, 32'h0000_0042);
    run_access(4'd8, 32'h0000_7F21, 32'hA5A5_A55A, 0, -1, 1'b0, 32'h0);
    run_access(4'd1, 32'h0000_0010, 32'h0, 2, 0, 1'b0, 32'h1357_9BDF);
    run_access(4'd6, 32'h0000_0014, 32'h1111_2222, 0, -1, 1'b1, 32'h0);

    // reset while a transaction is outstanding
    req_valid = 1'b1;
    mem_op    = 4'd1;
    addr      = 32'h0000_0020;
    #1;
    step();
    req_valid = 1'b0;
    #1;
    check("midwait_bus_req", bus_if.bus_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    model_rdata = '0;
    check("rstwait_bus_req", bus_if.bus_req, 0);
    check("rstwait_stall", stall, 0);
    check("rstwait_done", done, 0);
    check("rstwait_de_rdata", de_rdata, 0);
    step();
    check("rstwait_idle_bus_req", bus_if.bus_req, 0);
    run_access(4'd1, 32'h0000_0024, 32'h0, 1, -1, 1'b0, 32'hCAFE_F00D);

    // randomized accesses
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          w;
      int          fa;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      a  = rand_addr();
      w  = $urandom_range(0, 4);
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, w) : -1;
      run_access(op, a, $urandom, w, fa, ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage load/store controller. Takes a decoded load/store from the M pipeline stage, checks alignment and address range, runs a multi-cycle handshake with the data-memory/peripheral bus, and hands the raw read word, byte offset and extension opcode to the downstream data-extension unit (DE). Stalls the pipeline while a bus transaction is outstanding and raises AdEL/AdES instead of accessing the bus on a faulting address.

## Interface
- No parameters. Address map fixed: DM 0x0000_0000–0x0000_2FFF; Timer0 0x0000_7F00–0x0000_7F0B; Timer1 0x0000_7F10–0x0000_7F1B; interrupt generator 0x0000_7F20–0x0000_7F23.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  M-stage instruction is a load/store.
- mem_op  in  4  0 none, 1 lw, 2 lbu, 3 lb, 4 lhu, 5 lh, 6 sw, 7 sh, 8 sb; 9–15 treated as none.
- addr  in  32  effective address.
- wdata  in  32  store data (rt).
- flush  in  1  M-stage instruction is being cancelled (exception/eret upstream).
- bus_req  out  1  transaction request, held until bus_ready.
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- bus_byteen  out  4  write byte enables; 4'b0000 for loads.
- bus_wdata  out  32  replicated store data.
- bus_ready  in  1  bus completes transaction this cycle.
- bus_rdata  in  32  read word, valid with bus_ready.
- stall  out  1  freeze F/D/E/M.
- done  out  1  one-cycle pulse: access completed, de_* valid.
- de_rdata  out  32  registered bus_rdata (DE RDin).
- de_a  out  2  addr[1:0] of access (DE A).
- de_op  out  3  lw 000, lbu 001, lb 010, lhu 011, lh 100; 000 for stores.
- exc_valid  out  1  address exception on current request.
- exc_code  out  5  4 AdEL, 5 AdES; 0 when exc_valid low.

## Operation
- States: IDLE, WAIT, DONE. Reset → IDLE; all registered outputs 0.
- Exception check (combinational, IDLE only, req_valid=1, mem_op valid):
  - misaligned: lw/sw with addr[1:0]≠0; lh/lhu/sh with addr[0]=1.
  - out of range: address not in any map region.
  - sub-word (lb/lbu/lh/lhu/sh/sb) access to a timer region.
  - store to timer COUNT register (offset 0x8 of either timer).
  - addr computation overflow is not this block's concern.
  - load fault → exc_code 4, store fault → 5; exc_valid=1, no bus transaction, stall=0, stays IDLE.
- Accept: IDLE, req_valid, valid op, no exception, flush=0 → latch addr, op, byteen, wdata; go WAIT.
- Byte enables: sw 4'b1111; sh 4'b0011<<(2*addr[1]); sb 4'b0001<<addr[1:0]. wdata: sw as-is, sh {2{wdata[15:0]}}, sb {4{wdata[7:0]}}.
- WAIT: bus_req=1, bus_* driven from latched regs, stable until bus_ready. On bus_ready: capture bus_rdata into de_rdata (loads only; stores leave de_rdata unchanged), go DONE.
- DONE: done=1 for one cycle unless flushed; de_a/de_op hold latched values; req_valid ignored; → IDLE.
- flush in IDLE: suppresses accept and exc_valid. flush in WAIT: transaction cannot be aborted; completes normally, a sticky cancel bit suppresses done in DONE.
- reset in any state: → IDLE next edge, bus_req low, cancel bit cleared.

## Timing
- stall = (IDLE & accept condition) | WAIT. stall=0 in DONE so the pipeline advances with the completed access.
- Minimum load latency: accept cycle N, bus_req cycles N+1.., bus_ready at N+1 → done at N+2; stall high N and N+1.
- k wait states (bus_ready at N+1+k) → done at N+2+k.
- bus_req never high in IDLE or DONE; never two transactions back-to-back without passing DONE.
- exc_valid/exc_code combinational same cycle as request.

## Test plan
- lb addr 0x0000_0103, bus_ready at first bus_req cycle, rdata 0x8000_0000 → bus_addr 0x100, byteen 0000, done at N+2, de_a=3, de_op=010, de_rdata 0x8000_0000, stall high 2 cycles.
- sh addr 0x0000_0202 wdata 0x1234_ABCD, 3 wait states → byteen 1100, bus_wdata 0xABCD_ABCD, bus_req high 4 cycles, done at N+5.
- lw addr 0x0000_0006 → exc_valid=1, exc_code 4, bus_req never high, stall 0; sw addr 0x0000_7F08 → exc_code 5; lb 0x0000_7F00 → code 4; lw 0x0000_3000 → code 4.
- flush asserted in WAIT, bus_ready 2 cycles later → bus_req held until ready, no done pulse, IDLE after DONE.
- reset asserted mid-WAIT → next cycle IDLE, bus_req 0, stall 0, done 0; fresh lw afterwards completes normally.
